// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: tracks registers with outstanding loads, counts
// in-flight loads, and stalls, serialises or traps instructions before execute.

`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`endif
`ifndef ZONE_REGFILE
`define ZONE_REGFILE 2'd0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 2'd1
`endif
`ifndef ZONE_STOREQ
`define ZONE_STOREQ 2'd2
`endif

module issue_scoreboard #(
    parameter int C_LOADQ_DEPTH = 4,
    parameter int C_CNT_W       = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               ins_valid_i,
    input  logic               ins_err_i,
    input  logic               jump_i,
    input  logic               csr_access_i,
    input  logic [`ZONE_RANGE] zone_i,
    input  logic [4:0]         regd_addr_i,
    input  logic               regs1_rd_i,
    input  logic [4:0]         regs1_addr_i,
    input  logic               regs2_rd_i,
    input  logic [4:0]         regs2_addr_i,
    input  logic               wb_valid_i,
    input  logic [4:0]         wb_addr_i,
    input  logic               jump_done_i,
    input  logic               flush_i,
    output logic               ins_ready_o,
    output logic               issue_o,
    output logic               exception_o,
    output logic [C_CNT_W-1:0] loadq_cnt_o,
    output logic [31:0]        stall_cnt_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_JUMP = 2'd1,
        HALT      = 2'd2
    } state_t;

    localparam logic [C_CNT_W-1:0] DEPTH_C = C_CNT_W'(C_LOADQ_DEPTH);

    state_t             state_q, state_d;
    logic [31:0]        pending_q, pending_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               exception_d;
    logic               writes_rd, hazard, load_ok, csr_ok, load_issue, wb_dec;
    logic [31:0]        set_mask, clr_mask;

    // Handshake: ins_ready_o never looks at ins_valid_i; the instruction
    // transfers in the cycle where ins_valid_i and ins_ready_o are both high.
    always_comb begin
        writes_rd = ((zone_i == `ZONE_REGFILE) || (zone_i == `ZONE_LOADQ))
                    && !jump_i && (regd_addr_i != 5'd0);
        hazard    = (regs1_rd_i && pending_q[regs1_addr_i])
                  | (regs2_rd_i && pending_q[regs2_addr_i])
                  | (writes_rd  && pending_q[regd_addr_i]);
        load_ok   = (zone_i != `ZONE_LOADQ) || (count_q < DEPTH_C);
        csr_ok    = !csr_access_i || (count_q == '0);
        ins_ready_o = (state_q == RUN) && !ins_err_i && !hazard && load_ok && csr_ok;
        issue_o     = ins_valid_i && ins_ready_o;
        load_issue  = issue_o && (zone_i == `ZONE_LOADQ);
        wb_dec      = wb_valid_i && (count_q != '0);
    end

    // Set is applied after clear so a forced same-bit collision keeps the bit.
    always_comb begin
        set_mask  = (load_issue && regd_addr_i != 5'd0) ? (32'd1 << regd_addr_i) : 32'd0;
        clr_mask  = wb_valid_i ? (32'd1 << wb_addr_i) : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        if (load_issue && !wb_dec) begin
            count_d = count_q + 1'b1;
        end else if (!load_issue && wb_dec) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        exception_d = 1'b0;
        if (flush_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (ins_valid_i && ins_err_i) begin
                        state_d     = HALT;
                        exception_d = 1'b1;
                    end else if (issue_o && jump_i) begin
                        state_d = WAIT_JUMP;
                    end
                end
                WAIT_JUMP: if (jump_done_i) state_d = RUN;
                HALT:      state_d = HALT;
                default:   state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            pending_q   <= '0;
            count_q     <= '0;
            exception_o <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            exception_o <= exception_d;
            if (ins_valid_i && !ins_ready_o && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end

    assign loadq_cnt_o = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: table of ready/hazard vectors on a fixed
// pending state plus hand-written multi-cycle sequences and an issue-order queue.

`ifndef ZONE_RANGE
`define ZONE_RANGE 1:0
`endif
`ifndef ZONE_REGFILE
`define ZONE_REGFILE 2'd0
`endif
`ifndef ZONE_LOADQ
`define ZONE_LOADQ 2'd1
`endif
`ifndef ZONE_STOREQ
`define ZONE_STOREQ 2'd2
`endif

module tb_issue_scoreboard;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam logic [1:0] Z_REG = `ZONE_REGFILE;
    localparam logic [1:0] Z_LD  = `ZONE_LOADQ;
    localparam logic [1:0] Z_ST  = `ZONE_STOREQ;
    localparam logic [1:0] S_RUN = 2'd0, S_WJ = 2'd1, S_HALT = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ins_valid, ins_err, jump, csr_access;
    logic [1:0]    zone;
    logic [4:0]    regd_addr, regs1_addr, regs2_addr, wb_addr;
    logic          regs1_rd, regs2_rd, wb_valid, jump_done, flush;
    logic          ins_ready, issue, exception;
    logic [CW-1:0] loadq_cnt;
    logic [31:0]   stall_cnt;
    logic [1:0]    state;

    typedef struct {
        logic       valid, err, jmp, csr;
        logic [1:0] zone;
        logic [4:0] rd;
        logic       r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2;
        logic       exp_ready;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [4:0]  exp_q[$];
    vec_t        tbl[12];

    issue_scoreboard #(.C_LOADQ_DEPTH(DEPTH), .C_CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(rst),
        .ins_valid_i(ins_valid), .ins_err_i(ins_err), .jump_i(jump),
        .csr_access_i(csr_access), .zone_i(zone), .regd_addr_i(regd_addr),
        .regs1_rd_i(regs1_rd), .regs1_addr_i(regs1_addr),
        .regs2_rd_i(regs2_rd), .regs2_addr_i(regs2_addr),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .jump_done_i(jump_done), .flush_i(flush),
        .ins_ready_o(ins_ready), .issue_o(issue), .exception_o(exception),
        .loadq_cnt_o(loadq_cnt), .stall_cnt_o(stall_cnt), .state_o(state)
    );

    // ---- clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic e, input logic j, input logic c,
                                input logic [1:0] z, input logic [4:0] rd,
                                input logic r1, input logic [4:0] a1,
                                input logic r2, input logic [4:0] a2, input logic er);
        vec_t t;
        t.valid = v; t.err = e; t.jmp = j; t.csr = c; t.zone = z; t.rd = rd;
        t.r1 = r1; t.a1 = a1; t.r2 = r2; t.a2 = a2; t.exp_ready = er;
        return t;
    endfunction

    function automatic vec_t ld(input logic [4:0] rd);
        return mk(1, 0, 0, 0, Z_LD, rd, 0, 0, 0, 0, 1);
    endfunction

    task automatic set_ins(input vec_t t);
        ins_valid = t.valid; ins_err = t.err; jump = t.jmp; csr_access = t.csr;
        zone = t.zone; regd_addr = t.rd;
        regs1_rd = t.r1; regs1_addr = t.a1; regs2_rd = t.r2; regs2_addr = t.a2;
    endtask

    task automatic idle();
        set_ins(mk(0, 0, 0, 0, Z_REG, 0, 0, 0, 0, 0, 0));
        wb_valid = 0; wb_addr = 0; jump_done = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- scoreboard: issued rd must match the next expected instruction
    always @(negedge clk) begin
        if (!rst && issue) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {27'd0, regd_addr}, 32'hFFFF_FFFF);
            end else begin
                check("issue_order_rd", {27'd0, regd_addr}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_cnt", loadq_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_exc", exception, 0);
        check("rst_state", state, S_RUN);
        check("rst_ready", ins_ready, 1);
        tick();

        // load x5 then add x6,x5,x1: writeback in the third stall cycle
        set_ins(ld(5)); exp_q.push_back(5);
        @(negedge clk); check("raw_load_ready", ins_ready, 1);
        tick();
        set_ins(mk(1, 0, 0, 0, Z_REG, 6, 1, 5, 1, 1, 0)); exp_q.push_back(6);
        for (int c = 0; c < 3; c++) begin
            wb_valid = (c == 2); wb_addr = 5;
            @(negedge clk); check("raw_add_stall", ins_ready, 0);
            tick();
        end
        wb_valid = 0;
        @(negedge clk); check("raw_add_issue", issue, 1);
        tick(); idle();
        @(negedge clk);
        check("raw_stall_cnt", stall_cnt, 3);
        check("raw_cnt", loadq_cnt, 0);
        tick();

        // table: combinational ready with pending={x5}, count=1, valid held low
        set_ins(ld(5)); exp_q.push_back(5);
        tick(); idle();
        tbl[0]  = mk(0, 0, 0, 0, Z_REG, 6, 1, 5, 1, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, Z_REG, 6, 1, 1, 1, 5, 0);
        tbl[2]  = mk(0, 0, 0, 0, Z_REG, 6, 1, 1, 0, 5, 1);
        tbl[3]  = mk(0, 0, 0, 0, Z_REG, 5, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, Z_REG, 5, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, Z_ST,  5, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 0, 0, Z_REG, 9, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, Z_REG, 9, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, Z_LD,  9, 1, 3, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, Z_REG, 0, 1, 0, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, Z_LD,  5, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, Z_REG, 7, 0, 5, 1, 3, 1);
        for (int i = 0; i < 12; i++) begin
            set_ins(tbl[i]);
            @(negedge clk);
            check($sformatf("tbl_ready_%0d", i), ins_ready, tbl[i].exp_ready);
            tick();
        end
        idle();
        @(negedge clk);
        check("tbl_cnt", loadq_cnt, 1);
        check("tbl_stall_hold", stall_cnt, 3);
        wb_valid = 1; wb_addr = 5;
        tick(); idle();

        // five loads with depth 4: fifth waits for one writeback
        for (int i = 1; i <= 4; i++) begin
            set_ins(ld(5'(i))); exp_q.push_back(5'(i));
            @(negedge clk); check("ld4_ready", ins_ready, 1);
            tick();
        end
        set_ins(ld(5)); exp_q.push_back(5);
        wb_valid = 1; wb_addr = 1;
        @(negedge clk);
        check("ld5_full_stall", ins_ready, 0);
        check("ld5_cnt_full", loadq_cnt, 4);
        tick(); wb_valid = 0;
        @(negedge clk);
        check("ld5_issue", issue, 1);
        check("ld5_cnt_after_wb", loadq_cnt, 3);
        tick(); idle();
        @(negedge clk); check("ld5_cnt_stays", loadq_cnt, 4);
        for (int i = 2; i <= 5; i++) begin
            wb_valid = 1; wb_addr = 5'(i);
            tick();
        end
        idle();
        @(negedge clk); check("ld_drain_cnt", loadq_cnt, 0);
        tick();

        // CSR access waits for count to reach zero
        set_ins(ld(10)); exp_q.push_back(10); tick();
        set_ins(ld(11)); exp_q.push_back(11); tick();
        set_ins(mk(1, 0, 0, 1, Z_REG, 12, 0, 0, 0, 0, 1)); exp_q.push_back(12);
        wb_valid = 1; wb_addr = 10;
        @(negedge clk); check("csr_stall_cnt2", ins_ready, 0);
        check("csr_cnt2", loadq_cnt, 2);
        tick(); wb_addr = 11;
        @(negedge clk); check("csr_stall_cnt1", ins_ready, 0);
        tick(); wb_valid = 0;
        @(negedge clk); check("csr_issue", issue, 1);
        check("csr_cnt0", loadq_cnt, 0);
        tick(); idle();

        // branch: three stalled cycles, jump_done in the third
        set_ins(mk(1, 0, 1, 0, Z_REG, 0, 1, 1, 1, 2, 1)); exp_q.push_back(0);
        @(negedge clk); check("br_issue", issue, 1);
        tick();
        set_ins(mk(1, 0, 0, 0, Z_REG, 7, 1, 3, 0, 0, 1)); exp_q.push_back(7);
        for (int c = 0; c < 3; c++) begin
            jump_done = (c == 2);
            @(negedge clk);
            check("br_wait_ready", ins_ready, 0);
            check("br_wait_state", state, S_WJ);
            tick();
        end
        jump_done = 0;
        @(negedge clk); check("br_next_issue", issue, 1);
        check("br_state_run", state, S_RUN);
        tick(); idle();
        jump_done = 1;
        tick(); jump_done = 0;
        @(negedge clk); check("jd_in_run_ignored", state, S_RUN);
        tick();
        set_ins(mk(1, 0, 1, 0, Z_REG, 0, 0, 0, 0, 0, 1)); exp_q.push_back(0);
        tick(); idle();
        jump_done = 1; flush = 1;
        @(negedge clk); check("jdfl_state_wj", state, S_WJ);
        tick(); idle();
        @(negedge clk); check("jdfl_run", state, S_RUN);
        check("jdfl_ready", ins_ready, 1);
        tick();

        // illegal instruction: one exception pulse, HALT until flush
        set_ins(mk(1, 1, 0, 0, Z_REG, 9, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("ill_no_issue", issue, 0);
        check("ill_exc_before", exception, 0);
        tick();
        set_ins(mk(1, 0, 0, 0, Z_REG, 8, 0, 0, 0, 0, 1)); exp_q.push_back(8);
        @(negedge clk);
        check("ill_exc_pulse", exception, 1);
        check("ill_halt", state, S_HALT);
        check("ill_halt_ready", ins_ready, 0);
        tick();
        @(negedge clk);
        check("ill_exc_once", exception, 0);
        check("ill_halt_hold", ins_ready, 0);
        tick();
        flush = 1;
        @(negedge clk); check("ill_flush_cycle", ins_ready, 0);
        tick(); flush = 0;
        @(negedge clk);
        check("ill_after_flush", issue, 1);
        check("ill_state_run", state, S_RUN);
        tick(); idle();

        // async reset with count 3 and pending {x2,x7}
        set_ins(ld(2)); exp_q.push_back(2); tick();
        set_ins(ld(7)); exp_q.push_back(7); tick();
        set_ins(ld(0)); exp_q.push_back(0); tick();
        idle();
        set_ins(mk(0, 0, 0, 0, Z_REG, 3, 1, 2, 0, 0, 0));
        @(negedge clk);
        check("pre_rst_cnt", loadq_cnt, 3);
        check("pre_rst_dep_stall", ins_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt", loadq_cnt, 0);
        check("async_rst_stall", stall_cnt, 0);
        check("async_rst_ready", ins_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        set_ins(mk(1, 0, 0, 0, Z_REG, 3, 1, 2, 0, 0, 1)); exp_q.push_back(3);
        @(negedge clk); check("post_rst_issue", issue, 1);
        tick(); idle();
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue-stage controller between the instruction decoder and the execute/load-queue datapath.
- Tracks destination registers with outstanding loads in a per-register pending bitmap and counts in-flight loads.
- Stalls instructions with RAW/WAW hazards, serialises jumps and CSR accesses, and traps on illegal instructions.

Parameters:
C_LOADQ_DEPTH, 4, max in-flight loads (1..15)
C_CNT_W, 4, width of in-flight load counter, must hold C_LOADQ_DEPTH

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
ins_valid_i  in  1  decoded instruction present
ins_err_i  in  1  decoder illegal-instruction flag
jump_i  in  1  instruction is jal/jalr/branch
csr_access_i  in  1  instruction accesses a CSR
zone_i  in  `ZONE_RANGE  destination zone (`ZONE_REGFILE/`ZONE_LOADQ/`ZONE_STOREQ)
regd_addr_i  in  5  rd
regs1_rd_i  in  1  rs1 used
regs1_addr_i  in  5  rs1
regs2_rd_i  in  1  rs2 used
regs2_addr_i  in  5  rs2
wb_valid_i  in  1  load writeback this cycle
wb_addr_i  in  5  load writeback rd
jump_done_i  in  1  jump/branch resolved by execute
flush_i  in  1  pipeline flush / trap return
ins_ready_o  out  1  issue permitted (combinational)
issue_o  out  1  ins_valid_i & ins_ready_o
exception_o  out  1  one-cycle illegal-instruction pulse
loadq_cnt_o  out  C_CNT_W  in-flight load count
stall_cnt_o  out  32  saturating count of cycles with ins_valid_i & !ins_ready_o

Behaviour:
- Reset values: pending = 0, load count = 0, state = RUN, exception_o = 0, stall_cnt_o = 0.
- States:
  - RUN: issue allowed.
  - WAIT_JUMP: ins_ready_o = 0 until jump_done_i.
  - HALT: ins_ready_o = 0 until flush_i.
- Writes rd: zone_i is `ZONE_REGFILE or `ZONE_LOADQ, !jump_i (for jal/jalr, link is handled in execute), and rd != 0.
- Hazard: (regs1_rd_i & pending[rs1]) | (regs2_rd_i & pending[rs2]) | (writes rd & pending[rd]); all reads use registered pending.
  - A writeback clears its bit at the clock edge, so the dependent instruction issues one cycle later. There is no bypass.
- ins_ready_o = state==RUN & !ins_err_i & !hazard & load_ok & csr_ok.
  - load_ok = zone_i!=`ZONE_LOADQ | count < C_LOADQ_DEPTH.
  - csr_ok = !csr_access_i | count==0.
- Load issue (issue_o & zone_i==`ZONE_LOADQ): count+1. If rd != 0, set pending[rd].
- wb_valid_i: clear pending[wb_addr_i]. Count-1, saturating at 0; a writeback at count 0 changes nothing.
- Simultaneous load issue and writeback: count is unchanged. Set and clear of the same bit cannot coincide because of the WAW stall; if forced, set wins.
- Jump issue: next state WAIT_JUMP. jump_done_i in WAIT_JUMP returns to RUN the next cycle; jump_done_i in RUN is ignored.
- ins_valid_i & ins_err_i in RUN: exception_o = 1 for exactly one cycle, next state HALT, nothing issued.
- flush_i, any state: next state RUN; exception_o cleared.
  - pending and count are NOT cleared, because in-flight loads still write back.
  - flush_i has priority over jump_done_i and ins_err_i in the same cycle.
- pending[0] is permanently 0.
- stall_cnt_o: +1 on each cycle with ins_valid_i & !ins_ready_o; holds at 0xFFFFFFFF.
- Asserting reset_i mid-operation clears all state immediately (asynchronously).

Test Plan:
- Load to x5, then `add x6,x5,x1` the next cycle:
  - ready=0 until wb_valid_i, wb_addr_i=5.
  - Add issues one cycle after the writeback.
  - stall_cnt_o equals the stall cycles.
- Five back-to-back loads to x1..x5 with DEPTH=4 and no writeback:
  - First four issue; loadq_cnt_o=4; fifth stalls.
  - One writeback lets the fifth issue with cnt staying 4.
- CSR access with cnt=2: stalls until both writebacks arrive (cnt=0), then issues.
- Branch issued:
  - ready=0 for 3 cycles until jump_done_i; next instruction issues on the cycle after.
  - Also: jump_done_i and flush_i together -> RUN.
- ins_err_i=1 with valid:
  - exception_o pulses once and issue_o stays 0.
  - HALT holds until flush_i; the following valid instruction issues the next cycle.
- Reset asserted with cnt=3 and pending={x2,x7}: outputs clear immediately; x2-dependent instruction issues right after release.
